// File: rtl/alu_ops_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality helper.
package alu_ops_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1001;
   localparam logic [3:0] OP_DIV = 4'b1010;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIN  = 2'd2
   } state_e;

   // True for every opcode the sequencer implements.
   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB,
         OP_SLT, OP_MUL, OP_DIV, OP_NOR: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Issue/writeback handshake bundle between decode and the ALU sequencer.
interface alu_seq_ctrl_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [3:0]       ALUop;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             div_by_zero;
   logic             illegal_op;

   modport master (
      output start, a_in, b_in, ALUop,
      input  busy, done, result, zero, div_by_zero, illegal_op
   );

   modport slave (
      input  start, a_in, b_in, ALUop,
      output busy, done, result, zero, div_by_zero, illegal_op
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative datapath: unsigned shift-add multiply / restoring divide, one bit per step.
module muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_init,
   input  logic             i_step,
   input  logic             i_mode_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_prod_lo,
   output logic [WIDTH-1:0] o_quotient
);

   // r_acc: product accumulator or partial remainder
   // r_sh : shifting multiplicand or dividend/quotient
   // r_opb: shifting multiplier or fixed divisor
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_opb;
   logic             r_div;

   logic [WIDTH:0]   w_rs;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_rem_nx;

   // Restoring-divide trial subtraction; a successful subtract always fits in WIDTH bits.
   always_comb begin
      w_rs     = {r_acc, r_sh[WIDTH-1]};
      w_ge     = (w_rs >= {1'b0, r_opb});
      w_sub    = w_rs[WIDTH-1:0] - r_opb;
      w_rem_nx = w_ge ? w_sub : w_rs[WIDTH-1:0];
   end

   // Load operands on accept, then advance one bit per step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_sh  <= '0;
         r_opb <= '0;
         r_div <= 1'b0;
      end else if (i_init) begin
         r_acc <= '0;
         r_sh  <= i_a;
         r_opb <= i_b;
         r_div <= i_mode_div;
      end else if (i_step) begin
         if (r_div) begin
            r_acc <= w_rem_nx;
            r_sh  <= {r_sh[WIDTH-2:0], w_ge};
         end else begin
            if (r_opb[0]) begin
               r_acc <= r_acc + r_sh;
            end
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_opb <= {1'b0, r_opb[WIDTH-1:1]};
         end
      end
   end

   assign o_prod_lo  = r_acc;
   assign o_quotient = r_sh;

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: single-cycle logic/arith ops plus iterative MUL/DIV behind start/busy/done.
module alu_seq_ctrl
   import alu_ops_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_op;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_dbz;
   logic             r_ill;

   logic             w_init;
   logic             w_step;
   logic             w_mode_div;
   logic             w_long;
   logic [WIDTH-1:0] w_prod_lo;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_res;

   assign w_init     = (r_state == IDLE) && bus.start;
   assign w_step     = (r_state == ITER);
   assign w_mode_div = (bus.ALUop == OP_DIV);
   assign w_long     = (bus.ALUop == OP_MUL) ||
                       ((bus.ALUop == OP_DIV) && (bus.b_in != '0));

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_init     (w_init),
      .i_step     (w_step),
      .i_mode_div (w_mode_div),
      .i_a        (bus.a_in),
      .i_b        (bus.b_in),
      .o_prod_lo  (w_prod_lo),
      .o_quotient (w_quot)
   );

   // Result selection from latched operands; consumed only in FIN.
   always_comb begin
      w_res = '0;
      case (r_op)
         OP_AND:  w_res = r_a & r_b;
         OP_OR:   w_res = r_a | r_b;
         OP_ADD:  w_res = r_a + r_b;
         OP_SUB:  w_res = r_a - r_b;
         OP_SLT:  w_res = WIDTH'($signed(r_a) < $signed(r_b));
         OP_NOR:  w_res = ~(r_a | r_b);
         OP_MUL:  w_res = w_prod_lo;
         OP_DIV:  w_res = (r_b == '0) ? '1 : w_quot;
         default: w_res = '0;
      endcase
   end

   // Control FSM with registered handshake, result and flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_dbz    <= 1'b0;
         r_ill    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a    <= bus.a_in;
                  r_b    <= bus.b_in;
                  r_op   <= bus.ALUop;
                  r_busy <= 1'b1;
                  r_dbz  <= 1'b0;
                  r_ill  <= 1'b0;
                  if (w_long) begin
                     r_state <= ITER;
                     r_cnt   <= CNT_W'(WIDTH - 1);
                  end else begin
                     r_state <= FIN;
                  end
               end
            end
            ITER: begin
               if (r_cnt == '0) begin
                  r_state <= FIN;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            FIN: begin
               r_result <= w_res;
               r_zero   <= (w_res == '0);
               r_dbz    <= (r_op == OP_DIV) && (r_b == '0);
               r_ill    <= !op_legal(r_op);
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.result      = r_result;
   assign bus.zero        = r_zero;
   assign bus.div_by_zero = r_dbz;
   assign bus.illegal_op  = r_ill;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl.
module tb_alu_seq_ctrl;
   import alu_ops_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   lat;
   int   bcy;
   int   ndone;

   alu_seq_ctrl_if #(.WIDTH(32)) bus ();

   alu_seq_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: present op, let the next posedge accept it, count cycles to done.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int l, output int busy_cyc);
      bus.start = 1'b1;
      bus.ALUop = op;
      bus.a_in  = a;
      bus.b_in  = b;
      l = 0;
      busy_cyc = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         bus.a_in = 32'hDEAD_BEEF;
         bus.b_in = 32'h0BAD_F00D;
         if (bus.done) begin
            l = i;
            break;
         end
         if (bus.busy) busy_cyc++;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.ALUop = OP_AND;
      bus.a_in  = '0;
      bus.b_in  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_flags", {29'd0, bus.zero, bus.div_by_zero, bus.illegal_op}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD / SUB
      issue(OP_ADD, 32'd10, 32'd5, 1'b0, lat, bcy);
      chk("add_lat", 32'(lat), 32'd2);
      chk("add_busy", 32'(bcy), 32'd1);
      chk("add_res", bus.result, 32'd15);
      chk("add_zero", 32'(bus.zero), 32'd0);
      chk("add_busy_at_done", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("add_done_pulse", 32'(bus.done), 32'd0);
      chk("add_res_hold", bus.result, 32'd15);
      issue(OP_SUB, 32'd10, 32'd5, 1'b0, lat, bcy);
      chk("sub_lat", 32'(lat), 32'd2);
      chk("sub_res", bus.result, 32'd5);

      // MUL
      issue(OP_MUL, 32'd10, 32'd6, 1'b0, lat, bcy);
      chk("mul_lat", 32'(lat), 32'd34);
      chk("mul_busy", 32'(bcy), 32'd33);
      chk("mul_res", bus.result, 32'd60);
      issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, bcy);
      chk("mul_wrap_lat", 32'(lat), 32'd34);
      chk("mul_wrap_res", bus.result, 32'hFFFF_FFFE);

      // DIV
      issue(OP_DIV, 32'd10, 32'd5, 1'b0, lat, bcy);
      chk("div_lat", 32'(lat), 32'd34);
      chk("div_res", bus.result, 32'd2);
      chk("div_dbz", 32'(bus.div_by_zero), 32'd0);
      issue(OP_DIV, 32'd7, 32'd0, 1'b0, lat, bcy);
      chk("div0_lat", 32'(lat), 32'd2);
      chk("div0_res", bus.result, 32'hFFFF_FFFF);
      chk("div0_dbz", 32'(bus.div_by_zero), 32'd1);

      // Back-to-back logic and SLT with start held high
      issue(OP_AND, 32'd1, 32'd2, 1'b1, lat, bcy);
      chk("and_lat", 32'(lat), 32'd2);
      chk("and_res", bus.result, 32'd0);
      chk("and_zero", 32'(bus.zero), 32'd1);
      chk("and_dbz_clr", 32'(bus.div_by_zero), 32'd0);
      issue(OP_OR, 32'd1, 32'd2, 1'b1, lat, bcy);
      chk("or_lat", 32'(lat), 32'd2);
      chk("or_res", bus.result, 32'd3);
      chk("or_zero", 32'(bus.zero), 32'd0);
      issue(OP_NOR, 32'd1, 32'd2, 1'b1, lat, bcy);
      chk("nor_res", bus.result, 32'hFFFF_FFFC);
      issue(OP_SLT, 32'd10, 32'd5, 1'b1, lat, bcy);
      chk("slt_10_5", bus.result, 32'd0);
      issue(OP_SLT, 32'd5, 32'd10, 1'b1, lat, bcy);
      chk("slt_5_10", bus.result, 32'd1);
      issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, bcy);
      chk("slt_m1_1_lat", 32'(lat), 32'd2);
      chk("slt_m1_1", bus.result, 32'd1);

      // Start while busy is ignored
      bus.start = 1'b1;
      bus.ALUop = OP_MUL;
      bus.a_in  = 32'd10;
      bus.b_in  = 32'd6;
      lat = 0;
      ndone = 0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
         if (i == 5) begin
            bus.start = 1'b1;
            bus.ALUop = OP_ADD;
            bus.a_in  = 32'd1;
            bus.b_in  = 32'd1;
         end
         if (i == 6) bus.start = 1'b0;
         if (bus.done) begin
            ndone++;
            if (lat == 0) lat = i;
         end
      end
      chk("busy_ign_lat", 32'(lat), 32'd34);
      chk("busy_ign_ndone", 32'(ndone), 32'd1);
      chk("busy_ign_res", bus.result, 32'd60);

      // Reset in the middle of a DIV
      bus.start = 1'b1;
      bus.ALUop = OP_DIV;
      bus.a_in  = 32'd100;
      bus.b_in  = 32'd3;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
      end
      chk("mid_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_res", bus.result, 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("mid_rst_nodone", 32'(ndone), 32'd0);
      issue(OP_DIV, 32'd100, 32'd3, 1'b0, lat, bcy);
      chk("div100_lat", 32'(lat), 32'd34);
      chk("div100_res", bus.result, 32'd33);

      // Illegal opcode, then flag clears on next accept
      issue(4'b0011, 32'd9, 32'd9, 1'b0, lat, bcy);
      chk("ill_lat", 32'(lat), 32'd2);
      chk("ill_flag", 32'(bus.illegal_op), 32'd1);
      chk("ill_res", bus.result, 32'd0);
      chk("ill_zero", 32'(bus.zero), 32'd1);
      issue(OP_ADD, 32'd1, 32'd1, 1'b0, lat, bcy);
      chk("ill_clr", 32'(bus.illegal_op), 32'd0);
      chk("ill_clr_res", bus.result, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller around the 32-bit ALU operation set. Single-cycle ops are AND, OR, ADD, SUB, SLT and NOR. MUL and DIV run as iterative multi-cycle operations under an FSM. The block sits between the decode/issue stage and the writeback stage, and exchanges operands and results through a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result width; the MUL and DIV iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a_in  in  WIDTH  operand A
b_in  in  WIDTH  operand B
ALUop  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1001 MUL, 1010 DIV, 1100 NOR
busy  out  1  high from accept until done
done  out  1  one-cycle pulse; result/flags valid
result  out  WIDTH  registered result, held until next done
zero  out  1  registered (result == 0)
div_by_zero  out  1  registered; set with done for DIV when b_in == 0
illegal_op  out  1  registered; set with done for an unlisted opcode

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE; busy, done, zero, div_by_zero and illegal_op are 0; result is 0.
- States:
  - IDLE: on start=1, latch a_in, b_in and ALUop; busy goes high next cycle.
    - Single-cycle op, DIV with b=0, or illegal opcode: go to FIN.
    - MUL, or DIV with b≠0: go to ITER with count = WIDTH-1.
  - ITER: one shift step per cycle. Exit to FIN when count == 0, otherwise decrement the count.
  - FIN: write result and flags; go to IDLE. done=1 and busy=0 in the cycle after FIN.
- Latency from the accepting edge to done high:
  - single-cycle op: 2 cycles
  - MUL/DIV: WIDTH+2 cycles (34 for WIDTH=32)
- ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT is signed two's-complement: result 1 if a<b, else 0.
- NOR is ~(a|b).
- MUL is unsigned shift-add. result is the low WIDTH bits of the product; upper bits are discarded.
- DIV is unsigned restoring division. result is the quotient; the remainder is discarded.
- DIV by zero: result all ones, div_by_zero=1, no iteration.
- Illegal opcode: result 0, zero=1, illegal_op=1.
- Flags (div_by_zero, illegal_op) are cleared on the next accept.
- start while busy is ignored, and operands are not re-latched.
- start held high through done is accepted again in the IDLE cycle after FIN; back-to-back ops are allowed.
- Operand inputs may change freely after the accepting edge.
- rst_n low mid-ITER: the operation is aborted, all state returns to reset values, and no done is produced.
- done is never asserted outside the cycle after FIN.

Decomposition:
- Shared package alu_ops_pkg:
  - 4-bit opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL, OP_DIV, OP_NOR
  - FSM state encoding: IDLE, ITER, FIN
- Sub-module muldiv_iter holds the accumulator/remainder, the shifting multiplicand/quotient and the step logic.
  - It is controlled by init, step and mode (MUL/DIV) from the FSM.
  - It exposes prod_lo and quotient.
- Single-cycle ops are computed combinationally in the top level.

Test Plan:
- ADD a=10, b=5, start 1 cycle -> done 2 cycles after accept, result=15, zero=0; SUB 10,5 -> 5.
- MUL a=10, b=6 -> busy for 33 cycles, done at cycle 34, result=60; MUL 0xFFFFFFFF×2 -> 0xFFFFFFFE.
- DIV a=10, b=5 -> result=2 after 34 cycles; DIV 7/0 -> done at cycle 2, result=0xFFFFFFFF, div_by_zero=1.
- Logic and SLT, each op issued back-to-back with start held high:
  - AND 1,2 -> 0 with zero=1
  - OR 1,2 -> 3
  - NOR 1,2 -> 0xFFFFFFFC
  - SLT 10,5 -> 0
  - SLT 5,10 -> 1
  - SLT -1,1 -> 1
- Start while busy: during MUL 10×6, pulse start with ADD 1,1 at cycle 5 -> ignored, single done with result=60.
- Reset mid-DIV: drop rst_n at cycle 10 of DIV 100/3 -> busy=0, result=0 immediately, no done. A new DIV 100/3 after release -> result=33.
- Illegal opcode 0011 -> done at cycle 2, illegal_op=1, result=0, zero=1.
